// File: rtl/conv_pkg.sv
// Shared definitions for the strided convolution engines: FSM state codes,
// accumulator sizing and stride normalisation.
package conv_pkg;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] LOAD_KERNEL = 3'd1;
  localparam logic [2:0] LOAD_PIXELS = 3'd2;
  localparam logic [2:0] COMPUTE     = 3'd3;
  localparam logic [2:0] WRITE       = 3'd4;
  localparam logic [2:0] DONE        = 3'd5;

  function automatic int acc_width(input int pixel_bits);
    return 4 * pixel_bits;
  endfunction

  // A zero stride degenerates to 1; anything wider than the kernel clamps to K.
  function automatic int norm_stride(input int stride, input int k);
    if (stride == 0) return 1;
    if (stride > k) return k;
    return stride;
  endfunction

endpackage

// File: rtl/conv2d_addr_gen.sv
// Output-position and kernel-tap counters for the gather convolution, with the
// derived pixel / kernel / result RAM indices.
module conv2d_addr_gen
  import conv_pkg::*;
#(
  parameter int M   = 6,
  parameter int K   = 3,
  parameter int SW  = 2,
  parameter int OW  = 3,
  parameter int PW  = 6,
  parameter int KW  = 4,
  parameter int KCW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          tap_en,
  input  logic          out_en,
  input  logic [SW-1:0] s_eff,
  input  logic [OW-1:0] o_side,
  output logic [PW-1:0] pixel_idx,
  output logic [KW-1:0] kernel_idx,
  output logic [PW-1:0] result_idx,
  output logic          last_tap,
  output logic          last_output
);

  logic [KCW-1:0] kr_reg, kc_reg;
  logic [OW-1:0]  orow_reg, ocol_reg;
  int             row, col;

  always_comb begin
    row        = int'(orow_reg) * int'(s_eff) + int'(kr_reg);
    col        = int'(ocol_reg) * int'(s_eff) + int'(kc_reg);
    pixel_idx  = PW'(row * M + col);
    kernel_idx = KW'(int'(kr_reg) * K + int'(kc_reg));
    result_idx = PW'(int'(orow_reg) * int'(o_side) + int'(ocol_reg));
  end

  assign last_tap    = (kr_reg == KCW'(K-1)) && (kc_reg == KCW'(K-1));
  assign last_output = (orow_reg == o_side - OW'(1)) && (ocol_reg == o_side - OW'(1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      kr_reg   <= '0;
      kc_reg   <= '0;
      orow_reg <= '0;
      ocol_reg <= '0;
    end else begin
      if (tap_en) begin
        if (kc_reg == KCW'(K-1)) begin
          kc_reg <= '0;
          kr_reg <= (kr_reg == KCW'(K-1)) ? '0 : kr_reg + KCW'(1);
        end else begin
          kc_reg <= kc_reg + KCW'(1);
        end
      end
      if (out_en) begin
        if (ocol_reg == o_side - OW'(1)) begin
          ocol_reg <= '0;
          orow_reg <= (orow_reg == o_side - OW'(1)) ? '0 : orow_reg + OW'(1);
        end else begin
          ocol_reg <= ocol_reg + OW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multiply_unit.sv
// Unsigned combinational multiplier producing a full-width product.
module multiply_unit #(
  parameter int width = 8
) (
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] product
);

  assign product = a * b;

endmodule

// File: rtl/conv2d_gather.sv
// Forward strided 2-D convolution: loads a KxK kernel and an MxM tile, then
// accumulates one tap per cycle into an addressable result RAM.
module conv2d_gather
  import conv_pkg::*;
#(
  parameter int M          = 6,
  parameter int K          = 3,
  parameter int pixel_bits = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic                               strobe_signal_kernel,
  input  logic [pixel_bits-1:0]              kernel_weight,
  input  logic                               strobe_signal_pixel,
  input  logic [pixel_bits-1:0]              pixel,
  input  logic [$clog2(K+1)-1:0]             stride,
  input  logic [$clog2(M*M)-1:0]             result_address,
  output logic [acc_width(pixel_bits)-1:0]   final_output,
  output logic                               busy,
  output logic                               done
);

  localparam int AW    = acc_width(pixel_bits);
  localparam int SW    = $clog2(K+1);
  localparam int OW    = $clog2(M-K+2);
  localparam int PW    = $clog2(M*M);
  localparam int KW    = $clog2(K*K);
  localparam int KCW   = (K > 1) ? $clog2(K) : 1;
  localparam int KCNTW = $clog2(K*K+1);
  localparam int PCNTW = $clog2(M*M+1);

  logic [2:0]              state_reg;
  logic                    done_reg;
  logic [KCNTW-1:0]        kcnt_reg;
  logic [PCNTW-1:0]        pcnt_reg;
  logic [AW-1:0]           acc_reg;
  logic [SW-1:0]           s_eff_reg;
  logic [OW-1:0]           o_side_reg;
  logic [pixel_bits-1:0]   kernel_ram [K*K];
  logic [pixel_bits-1:0]   pixel_ram  [M*M];
  logic [AW-1:0]           result_ram [M*M];

  logic [PW-1:0]           pixel_idx, result_idx;
  logic [KW-1:0]           kernel_idx;
  logic                    last_tap, last_output;
  logic [2*pixel_bits-1:0] product;
  logic                    idle_or_done;
  int                      start_s;

  assign idle_or_done = (state_reg == IDLE) || (state_reg == DONE);
  assign busy         = !idle_or_done;
  assign done         = done_reg;
  assign start_s      = norm_stride(int'(stride), K);
  assign final_output = (int'(result_address) < M*M) ? result_ram[result_address] : '0;

  conv2d_addr_gen #(
    .M(M), .K(K), .SW(SW), .OW(OW), .PW(PW), .KW(KW), .KCW(KCW)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      ((state_reg != COMPUTE) && (state_reg != WRITE)),
    .tap_en     (state_reg == COMPUTE),
    .out_en     (state_reg == WRITE),
    .s_eff      (s_eff_reg),
    .o_side     (o_side_reg),
    .pixel_idx  (pixel_idx),
    .kernel_idx (kernel_idx),
    .result_idx (result_idx),
    .last_tap   (last_tap),
    .last_output(last_output)
  );

  multiply_unit #(.width(pixel_bits)) u_mul (
    .a      (pixel_ram[pixel_idx]),
    .b      (kernel_ram[kernel_idx]),
    .product(product)
  );

  // Load RAMs carry no reset: every entry is rewritten before COMPUTE reads it.
  always_ff @(posedge clk) begin
    if (state_reg == LOAD_KERNEL && strobe_signal_kernel)
      kernel_ram[kcnt_reg[KW-1:0]] <= kernel_weight;
    if (state_reg == LOAD_PIXELS && strobe_signal_pixel)
      pixel_ram[pcnt_reg[PW-1:0]] <= pixel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      done_reg   <= 1'b0;
      kcnt_reg   <= '0;
      pcnt_reg   <= '0;
      acc_reg    <= '0;
      s_eff_reg  <= SW'(1);
      o_side_reg <= OW'(1);
      for (int i = 0; i < M*M; i++) result_ram[i] <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (enable) begin
            for (int i = 0; i < M*M; i++) result_ram[i] <= '0;
            kcnt_reg   <= '0;
            pcnt_reg   <= '0;
            s_eff_reg  <= SW'(start_s);
            o_side_reg <= OW'((M-K)/start_s + 1);
            done_reg   <= 1'b0;
            state_reg  <= LOAD_KERNEL;
          end
        end
        LOAD_KERNEL: begin
          if (strobe_signal_kernel) begin
            kcnt_reg <= kcnt_reg + KCNTW'(1);
            if (kcnt_reg == KCNTW'(K*K-1)) state_reg <= LOAD_PIXELS;
          end
        end
        LOAD_PIXELS: begin
          if (strobe_signal_pixel) begin
            pcnt_reg <= pcnt_reg + PCNTW'(1);
            if (pcnt_reg == PCNTW'(M*M-1)) begin
              acc_reg   <= '0;
              state_reg <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          acc_reg <= acc_reg + AW'(product);
          if (last_tap) state_reg <= WRITE;
        end
        WRITE: begin
          result_ram[result_idx] <= acc_reg;
          acc_reg <= '0;
          if (last_output) begin
            done_reg  <= 1'b1;
            state_reg <= DONE;
          end else begin
            state_reg <= COMPUTE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_gather.sv
// Randomised and directed checks of conv2d_gather against a direct
// convolution model evaluated from the tile and kernel arrays.
module tb_conv2d_gather;

  localparam int M  = 6;
  localparam int K  = 3;
  localparam int PB = 8;
  localparam int AW = 4*PB;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          strobe_signal_kernel;
  logic [PB-1:0] kernel_weight;
  logic          strobe_signal_pixel;
  logic [PB-1:0] pixel;
  logic [1:0]    stride;
  logic [5:0]    result_address;
  logic [AW-1:0] final_output;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  int     kern [K*K];
  int     pix  [M*M];
  longint exp_res [64];
  int     exp_o;

  always #5 clk = ~clk;

  conv2d_gather #(.M(M), .K(K), .pixel_bits(PB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable              (enable),
    .strobe_signal_kernel(strobe_signal_kernel),
    .kernel_weight       (kernel_weight),
    .strobe_signal_pixel (strobe_signal_pixel),
    .pixel               (pixel),
    .stride              (stride),
    .result_address      (result_address),
    .final_output        (final_output),
    .busy                (busy),
    .done                (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Direct definition of a strided valid convolution.
  task automatic model(input int stride_in);
    int s;
    longint sum;
    s = (stride_in == 0) ? 1 : ((stride_in > K) ? K : stride_in);
    exp_o = (M - K) / s + 1;
    for (int a = 0; a < 64; a++) exp_res[a] = 0;
    for (int r = 0; r < exp_o; r++)
      for (int c = 0; c < exp_o; c++) begin
        sum = 0;
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            sum += longint'(pix[(r*s+i)*M + c*s+j]) * longint'(kern[i*K+j]);
        exp_res[r*exp_o+c] = sum;
      end
  endtask

  task automatic start_and_load(input int stride_in, input bit noise, input string name);
    enable = 1'b1;
    stride = 2'(stride_in);
    step();
    enable = 1'b0;
    check({name, " start_busy"}, 64'(busy), 64'd1);
    check({name, " start_done"}, 64'(done), 64'd0);
    if (noise) stride = 2'($urandom_range(0, 3));
    for (int i = 0; i < K*K; i++) begin
      while (noise && ($urandom_range(0, 2) == 0)) begin
        strobe_signal_kernel = 1'b0;
        strobe_signal_pixel  = 1'b1;
        pixel                = PB'($urandom);
        step();
      end
      strobe_signal_kernel = 1'b1;
      kernel_weight        = PB'(kern[i]);
      strobe_signal_pixel  = noise ? 1'($urandom) : 1'b0;
      pixel                = PB'($urandom);
      step();
    end
    strobe_signal_kernel = 1'b0;
    strobe_signal_pixel  = 1'b0;
    for (int i = 0; i < M*M; i++) begin
      while (noise && ($urandom_range(0, 2) == 0)) begin
        strobe_signal_pixel  = 1'b0;
        strobe_signal_kernel = 1'b1;
        kernel_weight        = PB'($urandom);
        step();
      end
      strobe_signal_pixel  = 1'b1;
      pixel                = PB'(pix[i]);
      strobe_signal_kernel = noise ? 1'($urandom) : 1'b0;
      kernel_weight        = PB'($urandom);
      step();
    end
    strobe_signal_pixel  = 1'b0;
    strobe_signal_kernel = 1'b0;
  endtask

  task automatic wait_done(input bit noise, input string name);
    int lat;
    lat = 0;
    while (!done && lat < 2000) begin
      if (noise) begin
        strobe_signal_kernel = 1'($urandom);
        strobe_signal_pixel  = 1'($urandom);
        kernel_weight        = PB'($urandom);
        pixel                = PB'($urandom);
      end
      step();
      lat++;
    end
    strobe_signal_kernel = 1'b0;
    strobe_signal_pixel  = 1'b0;
    check({name, " latency"}, 64'(lat), 64'(exp_o*exp_o*(K*K+1)));
    check({name, " done_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic check_results(input string name);
    for (int a = 0; a < 64; a++) begin
      result_address = 6'(a);
      #1;
      check($sformatf("%s res[%0d]", name, a), 64'(final_output), 64'(exp_res[a]));
    end
  endtask

  task automatic run_case(input int stride_in, input bit noise, input string name);
    model(stride_in);
    start_and_load(stride_in, noise, name);
    wait_done(noise, name);
    check_results(name);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; stride = 2'd1; result_address = '0;
    strobe_signal_kernel = 1'b0; kernel_weight = '0;
    strobe_signal_pixel = 1'b0; pixel = '0;
    repeat (3) step();
    rst = 1'b0;
    check("reset done", 64'(done), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset out0", 64'(final_output), 64'd0);

    for (int i = 0; i < K*K; i++) kern[i] = 1;
    for (int i = 0; i < M*M; i++) pix[i] = 1;
    run_case(1, 1'b0, "ones_s1");
    check("ones_s1 res0_is_9", 64'(exp_res[0]), 64'd9);

    for (int i = 0; i < K*K; i++) kern[i] = (i == 4) ? 1 : 0;
    for (int i = 0; i < M*M; i++) pix[i] = i;
    run_case(1, 1'b0, "centre");

    for (int i = 0; i < K*K; i++) kern[i] = 255;
    for (int i = 0; i < M*M; i++) pix[i] = 255;
    run_case(2, 1'b0, "max_s2");

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < K*K; i++) kern[i] = $urandom_range(0, 255);
      for (int i = 0; i < M*M; i++) pix[i] = $urandom_range(0, 255);
      run_case(t, (t % 2) == 1, $sformatf("rand_s%0d", t));
    end

    // Reset in the middle of COMPUTE must discard everything.
    for (int i = 0; i < K*K; i++) kern[i] = $urandom_range(1, 255);
    for (int i = 0; i < M*M; i++) pix[i] = $urandom_range(1, 255);
    model(1);
    start_and_load(1, 1'b0, "abort");
    repeat (37) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort done", 64'(done), 64'd0);
    check("abort busy", 64'(busy), 64'd0);
    for (int a = 0; a < 64; a++) begin
      result_address = 6'(a);
      #1;
      check($sformatf("abort cleared[%0d]", a), 64'(final_output), 64'd0);
    end
    run_case(1, 1'b1, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
